// File: rtl/fighter_pkg.sv
// Shared types and defaults for the fighter hit/damage logic.
// Provides the hit scheduler state encoding, player identifiers and
// default coordinate/damage widths used across the hit pipeline.
package fighter_pkg;

  localparam int unsigned NUM_SLOTS_DEF = 4;
  localparam int unsigned COORD_W_DEF   = 10;
  localparam int unsigned DMG_W_DEF     = 4;

  localparam logic PLAYER0 = 1'b0;
  localparam logic PLAYER1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    EVAL   = 3'd2,
    REPORT = 3'd3,
    DONE   = 3'd4
  } hs_state_t;

endpackage

// File: rtl/circle_contact.sv
// Circular contact test between point a and point b with radius r.
// contact is registered: it reflects the inputs of the previous cycle.
// Ports:
//   Clk, Reset_n   clock, synchronous active-low reset
//   ax, ay         attack centre
//   bx, by         target centre
//   radius         coverage radius
//   contact        1 when (ax-bx)^2 + (ay-by)^2 <= radius^2
module circle_contact #(
  parameter int unsigned COORD_W = fighter_pkg::COORD_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] radius,
  output logic               contact
);

  localparam int unsigned DIFF_W = COORD_W + 1;
  localparam int unsigned SQ_W   = 2 * DIFF_W;
  localparam int unsigned SUM_W  = SQ_W + 1;
  localparam int unsigned R2_W   = 2 * COORD_W;

  logic signed [DIFF_W-1:0] w_dx;
  logic signed [DIFF_W-1:0] w_dy;
  logic signed [SQ_W-1:0]   w_dx_ext;
  logic signed [SQ_W-1:0]   w_dy_ext;
  logic signed [SQ_W-1:0]   w_dx_sq;
  logic signed [SQ_W-1:0]   w_dy_sq;
  logic [SUM_W-1:0]         w_dist2;
  logic [R2_W-1:0]          w_r2;
  logic                     r_contact;

  // Zero-extend before subtracting so coordinates straddling zero give a true signed delta.
  assign w_dx     = $signed({1'b0, ax}) - $signed({1'b0, bx});
  assign w_dy     = $signed({1'b0, ay}) - $signed({1'b0, by});
  assign w_dx_ext = SQ_W'(w_dx);
  assign w_dy_ext = SQ_W'(w_dy);
  assign w_dx_sq  = w_dx_ext * w_dx_ext;
  assign w_dy_sq  = w_dy_ext * w_dy_ext;
  assign w_dist2  = SUM_W'($unsigned(w_dx_sq)) + SUM_W'($unsigned(w_dy_sq));
  assign w_r2     = R2_W'(radius) * R2_W'(radius);

  // Boundary counts as contact.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_contact <= 1'b0;
    end else begin
      r_contact <= (w_dist2 <= SUM_W'(w_r2));
    end
  end

  assign contact = r_contact;

endmodule

// File: rtl/hit_scheduler.sv
// Per-frame hit scheduler: walks the attack slots once per frame, tests
// each live slot against the opposing player with a shared contact
// comparator and reports every contact over a valid/ready handshake,
// clearing the slot so an attack lands at most once.
// Ports:
//   Clk, Reset_n                  clock, synchronous active-low reset
//   frame_start                   starts a scan (from vsync)
//   slot_valid/x/y/radius/owner/damage   live attack slot table (packed)
//   p0_x, p0_y, p1_x, p1_y        player centres, frozen at frame_start
//   hit_valid/ready, hit_player, hit_damage, hit_slot   hit event channel
//   slot_clear                    one-hot pulse in the hit handshake cycle
//   busy, frame_done, overrun     scan status
module hit_scheduler
  import fighter_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int unsigned COORD_W   = COORD_W_DEF,
  parameter int unsigned DMG_W     = DMG_W_DEF
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_start,
  input  logic [NUM_SLOTS-1:0]          slot_valid,
  input  logic [NUM_SLOTS*COORD_W-1:0]  slot_x,
  input  logic [NUM_SLOTS*COORD_W-1:0]  slot_y,
  input  logic [NUM_SLOTS*COORD_W-1:0]  slot_radius,
  input  logic [NUM_SLOTS-1:0]          slot_owner,
  input  logic [NUM_SLOTS*DMG_W-1:0]    slot_damage,
  input  logic [COORD_W-1:0]            p0_x,
  input  logic [COORD_W-1:0]            p0_y,
  input  logic [COORD_W-1:0]            p1_x,
  input  logic [COORD_W-1:0]            p1_y,
  output logic                          hit_valid,
  input  logic                          hit_ready,
  output logic                          hit_player,
  output logic [DMG_W-1:0]              hit_damage,
  output logic [$clog2(NUM_SLOTS)-1:0]  hit_slot,
  output logic [NUM_SLOTS-1:0]          slot_clear,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  hs_state_t          r_state;
  hs_state_t          w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic               w_snap;
  logic               w_issue;
  logic               w_advance;

  logic [COORD_W-1:0] r_p0_x, r_p0_y, r_p1_x, r_p1_y;
  logic               r_hit_valid;
  logic               r_hit_player;
  logic [DMG_W-1:0]   r_hit_damage;
  logic [IDX_W-1:0]   r_hit_slot;
  logic               r_busy;
  logic               r_frame_done;

  logic [COORD_W-1:0] w_sx, w_sy, w_sr;
  logic               w_owner;
  logic [DMG_W-1:0]   w_sdmg;
  logic [COORD_W-1:0] w_tx, w_ty;
  logic               w_contact;

  // Live slot selected by the scan index.
  assign w_sx    = slot_x[r_idx*COORD_W +: COORD_W];
  assign w_sy    = slot_y[r_idx*COORD_W +: COORD_W];
  assign w_sr    = slot_radius[r_idx*COORD_W +: COORD_W];
  assign w_owner = slot_owner[r_idx];
  assign w_sdmg  = slot_damage[r_idx*DMG_W +: DMG_W];

  // Target is the player who does not own the attack.
  assign w_tx = (w_owner == PLAYER0) ? r_p1_x : r_p0_x;
  assign w_ty = (w_owner == PLAYER0) ? r_p1_y : r_p0_y;

  // The comparator's input stage captures the issued slot at the SCAN edge,
  // so its result is valid exactly in the EVAL cycle.
  circle_contact #(
    .COORD_W (COORD_W)
  ) u_contact (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .ax      (w_sx),
    .ay      (w_sy),
    .bx      (w_tx),
    .by      (w_ty),
    .radius  (w_sr),
    .contact (w_contact)
  );

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_snap       = 1'b0;
    w_issue      = 1'b0;
    w_advance    = 1'b0;

    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_snap       = 1'b1;
          w_idx_next   = '0;
          w_state_next = SCAN;
        end
      end
      SCAN: begin
        if (slot_valid[r_idx]) begin
          w_issue      = 1'b1;
          w_state_next = EVAL;
        end else begin
          w_advance = 1'b1;
        end
      end
      EVAL: begin
        if (w_contact) begin
          w_state_next = REPORT;
        end else begin
          w_advance = 1'b1;
        end
      end
      REPORT: begin
        if (hit_ready) begin
          w_advance = 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // No wrap-around: the last slot always ends the frame.
    if (w_advance) begin
      if (r_idx == LAST_IDX) begin
        w_state_next = DONE;
      end else begin
        w_idx_next   = IDX_W'(r_idx + 1'b1);
        w_state_next = SCAN;
      end
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_p0_x       <= '0;
      r_p0_y       <= '0;
      r_p1_x       <= '0;
      r_p1_y       <= '0;
      r_hit_valid  <= 1'b0;
      r_hit_player <= 1'b0;
      r_hit_damage <= '0;
      r_hit_slot   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (w_snap) begin
        r_p0_x <= p0_x;
        r_p0_y <= p0_y;
        r_p1_x <= p1_x;
        r_p1_y <= p1_y;
      end
      if (w_issue) begin
        r_hit_player <= (w_owner == PLAYER0) ? PLAYER1 : PLAYER0;
        r_hit_damage <= w_sdmg;
        r_hit_slot   <= r_idx;
      end
      r_hit_valid  <= (w_state_next == REPORT);
      r_busy       <= (w_state_next == SCAN) || (w_state_next == EVAL) ||
                      (w_state_next == REPORT);
      r_frame_done <= (w_state_next == DONE);
    end
  end

  // Clear must coincide with the handshake, so it follows hit_ready directly;
  // gating with Reset_n keeps an aborted report from clearing its slot.
  always_comb begin
    slot_clear = '0;
    if (Reset_n && (r_state == REPORT) && hit_ready) begin
      slot_clear[r_idx] = 1'b1;
    end
  end

  assign overrun    = Reset_n && frame_start && (r_state != IDLE);
  assign hit_valid  = r_hit_valid;
  assign hit_player = r_hit_player;
  assign hit_damage = r_hit_damage;
  assign hit_slot   = r_hit_slot;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hit_scheduler.sv
// Directed bench for hit_scheduler with an event scoreboard.
module tb_hit_scheduler;

  localparam int NS = 4;
  localparam int CW = 10;
  localparam int DW = 4;

  typedef struct {
    bit player;
    int dmg;
    int slot;
  } ev_t;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic [NS-1:0]     slot_valid = '0;
  logic [NS*CW-1:0]  slot_x = '0;
  logic [NS*CW-1:0]  slot_y = '0;
  logic [NS*CW-1:0]  slot_radius = '0;
  logic [NS-1:0]     slot_owner = '0;
  logic [NS*DW-1:0]  slot_damage = '0;
  logic [CW-1:0]     p0_x = '0, p0_y = '0, p1_x = '0, p1_y = '0;
  logic              hit_valid;
  logic              hit_ready = 1'b1;
  logic              hit_player;
  logic [DW-1:0]     hit_damage;
  logic [1:0]        hit_slot;
  logic [NS-1:0]     slot_clear;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  int  n_cmp = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  int  stall_len = 0;
  int  stall_seen = 0;
  int  wait_cnt = 0;
  bit  force_ready = 1'b0;

  hit_scheduler dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .slot_valid  (slot_valid),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .slot_radius (slot_radius),
    .slot_owner  (slot_owner),
    .slot_damage (slot_damage),
    .p0_x        (p0_x),
    .p0_y        (p0_y),
    .p1_x        (p1_x),
    .p1_y        (p1_y),
    .hit_valid   (hit_valid),
    .hit_ready   (hit_ready),
    .hit_player  (hit_player),
    .hit_damage  (hit_damage),
    .hit_slot    (hit_slot),
    .slot_clear  (slot_clear),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Health-manager model: holds ready low for stall_len cycles per event.
  always @(posedge Clk) begin
    #1;
    if (force_ready) begin
      hit_ready = 1'b1;
    end else if (hit_valid !== 1'b1) begin
      wait_cnt  = 0;
      hit_ready = 1'b1;
    end else if (wait_cnt < stall_len) begin
      hit_ready = 1'b0;
      wait_cnt++;
    end else begin
      hit_ready = 1'b1;
    end
  end

  // Monitor: compares every presented hit against the scoreboard head.
  always @(negedge Clk) begin
    logic [NS-1:0] e_clr;
    if (Reset_n !== 1'b1) stall_seen = 0;
    if (Reset_n === 1'b1 && hit_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_hit: got slot %0d, expected no event", hit_slot);
      end else begin
        chk("hit_player", 32'(hit_player), 32'(exp_q[0].player));
        chk("hit_damage", 32'(hit_damage), 32'(exp_q[0].dmg));
        chk("hit_slot", 32'(hit_slot), 32'(exp_q[0].slot));
        if (hit_ready === 1'b1) begin
          e_clr = '0;
          e_clr[exp_q[0].slot] = 1'b1;
          chk("slot_clear_hs", 32'(slot_clear), 32'(e_clr));
          chk("stall_cycles", 32'(stall_seen), 32'(stall_len));
          void'(exp_q.pop_front());
          stall_seen = 0;
        end else begin
          chk("slot_clear_stall", 32'(slot_clear), 0);
          stall_seen++;
        end
      end
    end else begin
      chk("slot_clear_idle", 32'(slot_clear), 0);
    end
  end

  task automatic set_slot(input int i, input bit own, input int x, input int y,
                          input int r, input int d);
    slot_valid[i]          = 1'b1;
    slot_owner[i]          = own;
    slot_x[i*CW +: CW]      = CW'(x);
    slot_y[i*CW +: CW]      = CW'(y);
    slot_radius[i*CW +: CW] = CW'(r);
    slot_damage[i*DW +: DW] = DW'(d);
  endtask

  task automatic clear_slots();
    slot_valid = '0;
    slot_owner = '0;
  endtask

  task automatic set_players(input int ax, input int ay, input int bx, input int by);
    p0_x = CW'(ax); p0_y = CW'(ay); p1_x = CW'(bx); p1_y = CW'(by);
  endtask

  task automatic push_ev(input bit pl, input int d, input int s);
    ev_t e;
    e.player = pl; e.dmg = d; e.slot = s;
    exp_q.push_back(e);
  endtask

  // Offset 0 is the frame_start cycle; exp_done is the DONE-cycle offset.
  task automatic run_frame(input string nm, input int exp_done, input int ovr_at);
    bit seen;
    seen = 1'b0;
    for (int off = 0; off < 200 && !seen; off++) begin
      @(posedge Clk); #1;
      frame_start = (off == 0) || (off == ovr_at);
      @(negedge Clk);
      if (off == 0) chk({nm, "_no_overrun_idle"}, 32'(overrun), 0);
      if (off == 1) chk({nm, "_busy"}, 32'(busy), 1);
      if (ovr_at > 0 && off == ovr_at) chk({nm, "_overrun"}, 32'(overrun), 1);
      if (ovr_at > 0 && off == ovr_at + 1) chk({nm, "_overrun_pulse"}, 32'(overrun), 0);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        chk({nm, "_done_offset"}, 32'(off), 32'(exp_done));
        chk({nm, "_busy_in_done"}, 32'(busy), 0);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_done_timeout: got no frame_done, expected one by offset %0d", nm, exp_done);
    end
    @(posedge Clk); #1;
    frame_start = 1'b0;
    @(negedge Clk);
    chk({nm, "_done_pulse"}, 32'(frame_done), 0);
    chk({nm, "_idle_busy"}, 32'(busy), 0);
    chk({nm, "_events_left"}, 32'(exp_q.size()), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_hit_valid"}, 32'(hit_valid), 0);
    chk({nm, "_hit_player"}, 32'(hit_player), 0);
    chk({nm, "_hit_damage"}, 32'(hit_damage), 0);
    chk({nm, "_hit_slot"}, 32'(hit_slot), 0);
    chk({nm, "_slot_clear"}, 32'(slot_clear), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_frame_done"}, 32'(frame_done), 0);
    chk({nm, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    bit got;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_all_zero("reset");
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // Boundary hit: 3^2+4^2 = 25 = 5^2.
    set_players(500, 500, 100, 100);
    clear_slots();
    set_slot(0, 1'b0, 103, 104, 5, 3);
    push_ev(1'b1, 3, 0);
    run_frame("hit0", 7, -1);

    // Miss: 6^2 = 36 > 25; empty slots cost one cycle each.
    set_slot(0, 1'b0, 106, 100, 5, 3);
    run_frame("miss0", 6, -1);

    // Straddling zero: dx=-2, dy=3 -> 13.
    set_players(2, 0, 900, 900);
    clear_slots();
    set_slot(2, 1'b1, 0, 3, 3, 7);
    run_frame("zero_miss", 6, -1);
    set_slot(2, 1'b1, 0, 3, 4, 7);
    push_ev(1'b0, 7, 2);
    run_frame("zero_hit", 7, -1);

    // Two hits with backpressure.
    set_players(50, 60, 200, 300);
    clear_slots();
    set_slot(1, 1'b0, 200, 301, 2, 5);
    set_slot(3, 1'b1, 52, 60, 2, 11);
    push_ev(1'b1, 5, 1);
    push_ev(1'b0, 11, 3);
    stall_len = 5;
    run_frame("stall", 19, -1);
    stall_len = 0;

    // Worst case: every slot hits (radius 0 exact, r=10 boundary).
    clear_slots();
    set_slot(0, 1'b0, 200, 300, 0, 1);
    set_slot(1, 1'b1, 56, 68, 10, 2);
    set_slot(2, 1'b0, 197, 296, 5, 4);
    set_slot(3, 1'b1, 50, 60, 1, 15);
    push_ev(1'b1, 1, 0);
    push_ev(1'b0, 2, 1);
    push_ev(1'b1, 4, 2);
    push_ev(1'b0, 15, 3);
    run_frame("all4", 13, -1);

    // Radius 0 one pixel off misses; full-range boundary hit 1023^2.
    set_players(1023, 0, 200, 300);
    clear_slots();
    set_slot(0, 1'b0, 201, 300, 0, 6);
    set_slot(3, 1'b1, 0, 0, 1023, 9);
    push_ev(1'b0, 9, 3);
    run_frame("range", 8, -1);

    // Overrun mid-scan and in the DONE cycle.
    set_players(500, 500, 100, 100);
    clear_slots();
    set_slot(0, 1'b0, 103, 104, 5, 3);
    push_ev(1'b1, 3, 0);
    run_frame("ovr_mid", 7, 2);
    set_slot(0, 1'b0, 106, 100, 5, 3);
    run_frame("ovr_done", 6, 6);

    // Reset while a hit is held in REPORT.
    set_slot(0, 1'b0, 103, 104, 5, 3);
    push_ev(1'b1, 3, 0);
    stall_len = 1000;
    @(posedge Clk); #1;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      if (hit_valid === 1'b1) got = 1'b1;
    end
    chk("rst_hit_seen", 32'(got), 1);
    @(negedge Clk);
    force_ready = 1'b1;
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("rst_cycle_clear", 32'(slot_clear), 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    force_ready = 1'b0;
    @(negedge Clk);
    chk_all_zero("post_rst");
    exp_q.delete();
    stall_len = 0;
    push_ev(1'b1, 3, 0);
    run_frame("after_rst", 7, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
